// File: rtl/output_word_packer.sv
// Packs LANES pixels drained from the convolution output FIFO into one word on a
// valid/ready port; a flush emits the trailing partial word. Optional: OUTPUT_WORD_PACKER_STATS_EN.
module output_word_packer #(
   parameter int W     = 8,
   parameter int LANES = 4,
   parameter int CNT_W = 32
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       fifo_empty,
   input  logic [W-1:0]               fifo_rd_data,
   output logic                       fifo_rd_en,
   input  logic                       flush,
   output logic [W*LANES-1:0]         out_data,
   output logic [$clog2(LANES):0]     out_bytes,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CNT_W-1:0]           words_out
);

   localparam int IDX_W   = $clog2(LANES);
   localparam int BYTES_W = IDX_W + 1;
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(LANES - 1);
   localparam logic [BYTES_W-1:0] FULL_BYTES = BYTES_W'(LANES);

   typedef enum logic [1:0] {
      S_FILL,
      S_WAIT_DATA,
      S_PRESENT
   } state_t;

   state_t               state, state_d;
   logic [IDX_W-1:0]     idx, idx_d;
   logic [W*LANES-1:0]   lane_q, lane_d;
   logic [BYTES_W-1:0]   bytes_q, bytes_d;
   logic                 last_q, last_d;
   logic                 flush_pend, pend_d;
   logic                 handshake;

   assign out_valid = (state == S_PRESENT);
   assign out_data  = lane_q;
   assign out_bytes = bytes_q;
   assign out_last  = last_q;
   assign handshake = out_valid && out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational block.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= S_FILL;
         idx        <= '0;
         lane_q     <= '0;
         bytes_q    <= '0;
         last_q     <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_d;
         idx        <= idx_d;
         lane_q     <= lane_d;
         bytes_q    <= bytes_d;
         last_q     <= last_d;
         flush_pend <= pend_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state;
      idx_d      = idx;
      lane_d     = lane_q;
      bytes_d    = bytes_q;
      last_d     = last_q;
      pend_d     = flush_pend;
      fifo_rd_en = 1'b0;

      case (state)
         S_FILL: begin
            if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               state_d    = S_WAIT_DATA;
            end else if (flush_pend) begin
               // Flush only acts on an empty FIFO, so no pixel lands behind the partial word.
               if (idx != '0) begin
                  state_d = S_PRESENT;
                  bytes_d = {1'b0, idx};
                  last_d  = 1'b1;
               end else begin
                  pend_d = 1'b0;
               end
            end
         end
         S_WAIT_DATA: begin
            lane_d[idx*W +: W] = fifo_rd_data;
            if (idx == LAST_IDX) begin
               state_d = S_PRESENT;
               bytes_d = FULL_BYTES;
               last_d  = 1'b0;
               idx_d   = '0;
            end else begin
               idx_d   = idx + IDX_W'(1);
               state_d = S_FILL;
            end
         end
         S_PRESENT: begin
            if (out_ready) begin
               lane_d  = '0;
               idx_d   = '0;
               bytes_d = '0;
               last_d  = 1'b0;
               state_d = S_FILL;
               if (last_q) pend_d = 1'b0;
            end
         end
         default: state_d = S_FILL;
      endcase

      // A new end-of-frame request wins over any clear in the same cycle.
      if (flush) pend_d = 1'b1;
   end

`ifdef OUTPUT_WORD_PACKER_STATS_EN
   logic [CNT_W-1:0] words_q;

   always_ff @(posedge clk) begin
      if (!rstn)          words_q <= '0;
      else if (handshake) words_q <= words_q + CNT_W'(1);
   end

   assign words_out = words_q;
`else
   assign words_out = '0;
`endif

endmodule

// File: doc/output_word_packer.md
Name: output_word_packer

Overview:
- Downstream consumer of the convolution output FIFO. Drains 8-bit result pixels through the FIFO's read port (rd_en / rd_data / empty).
- Packs LANES pixels into one W*LANES-bit word and presents it on a valid/ready interface to the LiteX CSR/DMA readout side.
- A flush request emits a trailing partial word at end of frame.

Parameters:
- W, 8, pixel width in bits; must equal the FIFO data width.
- LANES, 4, pixels per output word; power of two, at least 2.
- CNT_W, 32, width of the optional word statistics counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  W  FIFO read data; valid exactly one cycle after an accepted fifo_rd_en.
- fifo_rd_en  out  1  FIFO pop request.
- flush  in  1  single-cycle pulse; end of frame, emit partial word.
- out_data  out  W*LANES  packed word; first pixel in bits [W-1:0].
- out_bytes  out  $clog2(LANES)+1  number of valid pixels in out_data (1..LANES).
- out_last  out  1  word was produced by a flush.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts word.
- words_out  out  CNT_W  count of words accepted (optional feature).

Behaviour:
- Reset is rstn, synchronous, active-low; clock is clk.
- Reset values:
  - out_data=0, out_bytes=0, out_last=0, out_valid=0, words_out=0.
  - fifo_rd_en=0.
  - lane index=0, flush_pend=0, state=FILL.
- FIFO contract: fifo_rd_en is asserted only when fifo_empty=0. fifo_rd_data is sampled on the cycle after the pop.
- State machine: FILL, WAIT_DATA, PRESENT.
- FILL:
  - fifo_rd_en = (state==FILL && !fifo_empty). This is a combinational decode, high for exactly one cycle per pixel.
  - If a pop is issued, go to WAIT_DATA.
  - Else if fifo_empty=1, flush_pend=1 and idx>0: go to PRESENT with out_bytes=idx and out_last=1. Unfilled lanes read 0.
  - Else if fifo_empty=1, flush_pend=1 and idx=0: clear flush_pend, stay in FILL, emit no word.
- WAIT_DATA:
  - Write fifo_rd_data into lane[idx] (bits idx*W +: W).
  - If idx==LANES-1: go to PRESENT with out_bytes=LANES, out_last=0, idx=0.
  - Otherwise: idx+1 and return to FILL.
- PRESENT:
  - out_valid=1. out_data, out_bytes and out_last are held stable until out_ready=1.
  - On the handshake (out_valid && out_ready): clear the lane register, idx=0, out_valid=0 next cycle, return to FILL.
  - If out_last was 1, clear flush_pend on the handshake.
- Throughput: one pixel per 2 cycles; one cycle of bubble per word after the handshake. No pops occur in PRESENT, giving back-pressure to the FIFO.
- flush:
  - A pulse sets flush_pend in any state. A pulse while flush_pend=1 is absorbed.
  - Flush takes effect only once the FIFO is empty, so no pixel is ever reordered behind a partial word.
- Flush coinciding with a full word: if flush arrives while a full word is in PRESENT and the FIFO is then empty with idx=0, flush_pend clears in FILL with no extra word. out_last stays 0 on that full word.
- Reset mid-operation: captured pixels are discarded. Any FIFO data returning the cycle after reset is ignored, because state is FILL, not WAIT_DATA.
- Arithmetic: idx is $clog2(LANES) bits. out_bytes = idx zero-extended; LANES fits because of the extra bit.

Optional Feature:
- Macro: OUTPUT_WORD_PACKER_STATS_EN.
- Defined: words_out increments by 1 on every out_valid && out_ready. It wraps modulo 2^CNT_W and is cleared by reset.
- Undefined: words_out is tied to 0 and no counter logic is generated.

Test Plan:
- FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> one word:
  - out_data=0x44332211, out_bytes=4, out_last=0.
  - fifo_rd_en pulses exactly 4 times, never while fifo_empty=1.
- FIFO holds 0xAA,0xBB, then flush pulse -> out_data=0x0000BBAA, out_bytes=2, out_last=1. FIFO left untouched afterwards.
- Eight pixels 0x01..0x08 with out_ready=0 for 10 cycles after the first word:
  - out_data=0x04030201 held stable with out_valid=1 and no pops.
  - After out_ready: second word 0x08070605.
- Flush with FIFO empty and idx=0 -> no out_valid; flush_pend cleared; a subsequent 4 pixels yield a normal word with out_last=0.
- rstn low for 1 cycle while idx=2 in WAIT_DATA -> all outputs at reset values. The next 4 pixels 0x10..0x13 produce 0x13121110.
- With OUTPUT_WORD_PACKER_STATS_EN defined, 3 accepted words -> words_out=3. Undefined -> words_out=0 throughout.
